// File: rtl/regfile_we_bank.sv
// ============================================================================
// regfile_we_bank : byte-strobed register file, two registered read ports,
//                   write bypass and a one-entry-per-cycle clear sweep.
// Revision 1.0
// ============================================================================
`default_nettype none

module regfile_we_bank #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int NB = WIDTH / 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [NB-1:0]    wstrb,
    input  logic             re_a,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic             re_b,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             clr_req,
    output logic             clr_busy,
    output logic [DEPTH-1:0] valid_mask,
    output logic             err_drop
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state;
    logic [AW-1:0]    clr_idx;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] rd_next_a;
    logic [WIDTH-1:0] rd_next_b;
    logic             wr_acc;

    assign wr_acc = we && !clr_busy;

    for (genvar b = 0; b < NB; b++) begin : g_byte
        assign merged[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : mem[waddr][8*b +: 8];
    end

    // Read data reflects the entry as it will be after this edge: a clear wins,
    // and clear and write never coincide because writes are dropped while busy.
    always_comb begin
        rd_next_a = mem[raddr_a];
        if (clr_busy && clr_idx == raddr_a) begin
            rd_next_a = '0;
        end else if (wr_acc && waddr == raddr_a) begin
            rd_next_a = merged;
        end
    end

    always_comb begin
        rd_next_b = mem[raddr_b];
        if (clr_busy && clr_idx == raddr_b) begin
            rd_next_b = '0;
        end else if (wr_acc && waddr == raddr_b) begin
            rd_next_b = merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            clr_busy   <= 1'b0;
            clr_idx    <= '0;
            err_drop   <= 1'b0;
            rdata_a    <= '0;
            rdata_b    <= '0;
            valid_mask <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            err_drop <= we && clr_busy;
            if (re_a) begin
                rdata_a <= rd_next_a;
            end
            if (re_b) begin
                rdata_b <= rd_next_b;
            end
            if (wr_acc) begin
                mem[waddr]        <= merged;
                valid_mask[waddr] <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state    <= CLEAR;
                        clr_busy <= 1'b1;
                        clr_idx  <= '0;
                    end
                end
                CLEAR: begin
                    mem[clr_idx]        <= '0;
                    valid_mask[clr_idx] <= 1'b0;
                    clr_idx             <= clr_idx + AW'(1);
                    if (clr_idx == LAST_IDX) begin
                        state    <= IDLE;
                        clr_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
